// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decoder and execute unit with an iterative
// multiply/divide engine that owns the HI/LO registers.
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   in_valid / in_ready    issue handshake (ready only while idle)
//   alu_op, funct, a, b    main-control op, R-type funct, operands
//   alu_ctr                combinational decode of the presented op
//   result, out_valid,zero registered simple-op result, 1-cycle valid, zero flag
//   md_done                1-cycle pulse when HI/LO are written by mult/div
//   illegal                1-cycle pulse when an unknown funct is accepted
//   hi, lo                 HI/LO registers
module alu_ctrl_mdu #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          SLT_SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [3:0]       alu_ctr,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             md_done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO,
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_ILL
    } op_t;

    state_t           state, state_nxt;
    op_t              op;
    logic [PW-1:0]    p;        // mult: {partial product, multiplier}; div: {remainder, dividend}
    logic [WIDTH-1:0] dvs;      // mult: multiplicand magnitude; div: divisor magnitude
    logic [CW-1:0]    cnt;
    logic             md_div, neg_q, neg_r, dvz;
    logic             accept, is_md, md_sgn;
    logic [WIDTH-1:0] simple_res, mag_a, mag_b;
    logic [WIDTH:0]   mul_sum, r_sh;
    logic [WIDTH-1:0] div_rem;
    logic             div_qbit;
    logic [PW-1:0]    prod_neg;

    // Decode main-control op and funct.
    always_comb begin
        op = OP_ILL;
        if (!alu_op[1]) begin
            op = alu_op[0] ? OP_SUB : OP_ADD;
        end else begin
            case (funct)
                6'b100000: op = OP_ADD;
                6'b100010: op = OP_SUB;
                6'b100100: op = OP_AND;
                6'b100101: op = OP_OR;
                6'b101010: op = OP_SLT;
                6'b011000: op = OP_MULT;
                6'b011001: op = OP_MULTU;
                6'b011010: op = OP_DIV;
                6'b011011: op = OP_DIVU;
                6'b010000: op = OP_MFHI;
                6'b010010: op = OP_MFLO;
                default:   op = OP_ILL;
            endcase
        end
    end

    always_comb begin
        case (op)
            OP_ADD:  alu_ctr = 4'b0010;
            OP_SUB:  alu_ctr = 4'b0110;
            OP_AND:  alu_ctr = 4'b0000;
            OP_OR:   alu_ctr = 4'b0001;
            OP_SLT:  alu_ctr = 4'b0111;
            default: alu_ctr = 4'b1111;
        endcase
    end

    // Single-cycle result for simple ops; illegal yields zero.
    always_comb begin
        simple_res = '0;
        case (op)
            OP_ADD:  simple_res = a + b;
            OP_SUB:  simple_res = a - b;
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_SLT:  simple_res = WIDTH'(SLT_SIGNED ? ($signed(a) < $signed(b)) : (a < b));
            OP_MFHI: simple_res = hi;
            OP_MFLO: simple_res = lo;
            default: simple_res = '0;
        endcase
    end

    assign is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign md_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign accept = in_valid && in_ready;
    assign mag_a  = (md_sgn && a[WIDTH-1]) ? WIDTH'(-a) : a;
    assign mag_b  = (md_sgn && b[WIDTH-1]) ? WIDTH'(-b) : b;

    // Shift-add step: add multiplicand when multiplier LSB set, then shift right.
    assign mul_sum = {1'b0, p[PW-1:WIDTH]} + (p[0] ? {1'b0, dvs} : {(WIDTH+1){1'b0}});

    // Restoring-division step: shift in next dividend bit, subtract if it fits.
    assign r_sh     = {p[PW-1:WIDTH], p[WIDTH-1]};
    assign div_qbit = (r_sh >= {1'b0, dvs});
    assign div_rem  = div_qbit ? WIDTH'(r_sh - {1'b0, dvs}) : r_sh[WIDTH-1:0];
    assign prod_neg = PW'(-p);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_md) state_nxt = ((op == OP_DIV) || (op == OP_DIVU)) ? DIV : MUL;
            MUL,
            DIV:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready = 1'b0;
        if (state == IDLE) in_ready = 1'b1;
    end

    // Datapath: result/flag registers and the mult/div engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result    <= '0;
            out_valid <= 1'b0;
            zero      <= 1'b0;
            md_done   <= 1'b0;
            illegal   <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            p         <= '0;
            dvs       <= '0;
            cnt       <= '0;
            md_div    <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dvz       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            zero      <= 1'b0;
            md_done   <= 1'b0;
            illegal   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_md) begin
                            md_div <= (op == OP_DIV) || (op == OP_DIVU);
                            neg_q  <= md_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r  <= md_sgn && a[WIDTH-1];
                            dvz    <= (b == '0);
                            cnt    <= '0;
                            if ((op == OP_DIV) || (op == OP_DIVU)) begin
                                p   <= {{WIDTH{1'b0}}, mag_a};
                                dvs <= mag_b;
                            end else begin
                                p   <= {{WIDTH{1'b0}}, mag_b};
                                dvs <= mag_a;
                            end
                        end else begin
                            result    <= simple_res;
                            out_valid <= 1'b1;
                            zero      <= (simple_res == '0);
                            illegal   <= (op == OP_ILL);
                        end
                    end
                end
                MUL: begin
                    p   <= {mul_sum, p[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    p   <= {div_rem, p[WIDTH-2:0], div_qbit};
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    md_done <= 1'b1;
                    if (md_div) begin
                        // Divide by zero: quotient all ones, remainder restores to a.
                        lo <= dvz ? {WIDTH{1'b1}} : (neg_q ? WIDTH'(-p[WIDTH-1:0]) : p[WIDTH-1:0]);
                        hi <= neg_r ? WIDTH'(-p[PW-1:WIDTH]) : p[PW-1:WIDTH];
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : p;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 8;

    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                           F_OR = 6'b100101, F_SLT = 6'b101010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001, F_DIV = 6'b011010, F_DIVU = 6'b011011,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, out_valid, zero, md_done, illegal;
    logic [1:0]    alu_op;
    logic [5:0]    funct;
    logic [W-1:0]  a, b, result, hi, lo;
    logic [3:0]    alu_ctr;

    logic          s_in_valid, s_in_ready, s_out_valid, s_zero, s_md_done, s_illegal;
    logic [1:0]    s_alu_op;
    logic [5:0]    s_funct;
    logic [SW-1:0] s_a, s_b, s_result, s_hi, s_lo;
    logic [3:0]    s_alu_ctr;

    alu_ctrl_mdu #(.WIDTH(W), .SLT_SIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .a(a), .b(b), .alu_ctr(alu_ctr),
        .result(result), .out_valid(out_valid), .zero(zero), .md_done(md_done),
        .illegal(illegal), .hi(hi), .lo(lo)
    );

    alu_ctrl_mdu #(.WIDTH(SW), .SLT_SIGNED(1'b0)) dut8 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .alu_op(s_alu_op), .funct(s_funct), .a(s_a), .b(s_b), .alu_ctr(s_alu_ctr),
        .result(s_result), .out_valid(s_out_valid), .zero(s_zero), .md_done(s_md_done),
        .illegal(s_illegal), .hi(s_hi), .lo(s_lo)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [W-1:0] mh = '0;
    logic [W-1:0] ml = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctr(input logic [1:0] op, input logic [5:0] f);
        if (!op[1]) return op[0] ? 4'b0110 : 4'b0010;
        case (f)
            F_ADD:   return 4'b0010;
            F_SUB:   return 4'b0110;
            F_AND:   return 4'b0000;
            F_OR:    return 4'b0001;
            F_SLT:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic ref_is_md(input logic [1:0] op, input logic [5:0] f);
        return op[1] && (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
    endfunction

    function automatic logic ref_illegal(input logic [1:0] op, input logic [5:0] f);
        if (!op[1]) return 1'b0;
        return !(f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_SLT ||
                 f == F_MFHI || f == F_MFLO || ref_is_md(op, f));
    endfunction

    function automatic logic [W-1:0] ref_simple(input logic [1:0] op, input logic [5:0] f,
                                                input logic [W-1:0] x, input logic [W-1:0] y);
        if (!op[1]) return op[0] ? x - y : x + y;
        case (f)
            F_ADD:   return x + y;
            F_SUB:   return x - y;
            F_AND:   return x & y;
            F_OR:    return x | y;
            F_SLT:   return ($signed(x) < $signed(y)) ? 1 : 0;
            F_MFHI:  return mh;
            F_MFLO:  return ml;
            default: return '0;
        endcase
    endfunction

    // Reference HI/LO from plain arithmetic.
    task automatic ref_md(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sx, sy;
        sx = x;
        sy = y;
        case (f)
            F_MULT: begin
                sp = 64'(sx) * 64'(sy);
                {mh, ml} = sp;
            end
            F_MULTU: begin
                up = {32'b0, x} * {32'b0, y};
                {mh, ml} = up;
            end
            F_DIV: begin
                if (y == 0) begin ml = '1; mh = x; end
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin ml = 32'h8000_0000; mh = '0; end
                else begin ml = sx / sy; mh = sx % sy; end
            end
            default: begin
                if (y == 0) begin ml = '1; mh = x; end
                else begin ml = x / y; mh = x % y; end
            end
        endcase
    endtask

    // Issue one simple op starting just after a rising edge; checks the next-cycle output.
    task automatic simple_op(input logic [1:0] op, input logic [5:0] f,
                             input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] exp;
        exp = ref_simple(op, f, x, y);
        alu_op = op; funct = f; a = x; b = y; in_valid = 1'b1;
        #1;
        chk("alu_ctr", alu_ctr, ref_ctr(op, f));
        chk("in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("out_valid", out_valid, 1'b1);
        chk("result", result, exp);
        chk("zero", zero, exp == 0);
        chk("illegal", illegal, ref_illegal(op, f));
    endtask

    // Issue a mult/div op and wait for md_done; optionally keep in_valid high while busy.
    task automatic md_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic poke);
        int   n;
        logic seen_out, seen_ready;
        alu_op = 2'b10; funct = f; a = x; b = y; in_valid = 1'b1;
        #1;
        chk("md_ctr", alu_ctr, 4'b1111);
        chk("md_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        ref_md(f, x, y);
        in_valid = poke; funct = F_ADD; a = $urandom; b = $urandom;
        n = 0; seen_out = 1'b0; seen_ready = 1'b0;
        while (!md_done && n < 200) begin
            if (out_valid || illegal) seen_out = 1'b1;
            if (in_ready) seen_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        chk("md_latency", 64'(n), 64'(W + 1));
        chk("md_busy_pulse", seen_out, 1'b0);
        chk("md_busy_ready", seen_ready, 1'b0);
        chk("md_done_ready", in_ready, 1'b1);
        chk("md_done_ov", out_valid, 1'b0);
        chk("md_hi", hi, mh);
        chk("md_lo", lo, ml);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return W'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ftab [0:11];
        logic [1:0] rop;
        logic [5:0] rf;
        logic       seen;
        int         n;

        ftab = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_MFHI, F_MFLO,
                 F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b111111};
        reset = 1'b1; in_valid = 1'b0; alu_op = '0; funct = '0; a = '0; b = '0;
        s_in_valid = 1'b0; s_alu_op = '0; s_funct = '0; s_a = '0; s_b = '0;
        #12;
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_result", result, '0);
        chk("rst_hi", hi, '0);
        chk("rst_lo", lo, '0);
        chk("rst_flags", {out_valid, md_done, illegal}, 3'b000);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        // sub then slt back-to-back, then the pulse must drop
        simple_op(2'b10, F_SUB, 5, 7);
        chk("sub_const", result, 32'hFFFF_FFFE);
        simple_op(2'b10, F_SLT, 5, 7);
        chk("slt_const", result, 1);
        @(posedge clk); #1;
        chk("ov_pulse_end", out_valid, 1'b0);
        simple_op(2'b00, F_MFHI, 10, 3);
        simple_op(2'b01, F_SLT, 3, 3);

        // signed multiply, then read LO
        md_op(F_MULT, 32'hFFFF_FFFD, 7, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFF_FFFF);
        chk("mult_lo_const", lo, 32'hFFFF_FFEB);
        simple_op(2'b10, F_MFLO, 0, 0);
        chk("mflo_const", result, 32'hFFFF_FFEB);
        chk("md_done_pulse_end", md_done, 1'b0);

        // reset in the middle of a multiply
        alu_op = 2'b10; funct = F_MULT; a = 123; b = 456; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        mh = '0; ml = '0;
        chk("midrst_hi", hi, '0);
        chk("midrst_lo", lo, '0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_md_done", md_done, 1'b0);
        @(negedge clk); reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (md_done) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 1'b0);
        chk("midrst_lo_kept", lo, '0);

        // division corners
        md_op(F_DIV, -32'sd7, 2, 1'b0);
        chk("div_lo_const", lo, 32'hFFFF_FFFD);
        chk("div_hi_const", hi, 32'hFFFF_FFFF);
        md_op(F_DIVU, 7, 0, 1'b0);
        chk("divu0_lo_const", lo, 32'hFFFF_FFFF);
        chk("divu0_hi_const", hi, 7);
        md_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_op(F_DIV, -32'sd9, 0, 1'b0);

        // illegal funct, and issue attempts while dividing
        simple_op(2'b10, 6'b111111, 1, 2);
        @(posedge clk); #1;
        chk("illegal_pulse_end", illegal, 1'b0);
        md_op(F_DIVU, 100, 7, 1'b1);

        // randomized mix against the reference model
        repeat (60) begin
            rf  = ftab[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) rf = 6'($urandom);
            rop = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 1)) : 2'b10;
            if (ref_is_md(rop, rf)) md_op(rf, pick(), pick(), 1'($urandom_range(0, 1)));
            else                    simple_op(rop, rf, pick(), pick());
        end

        // narrow instance: unsigned multiply latency and unsigned slt
        @(posedge clk); #1;
        s_alu_op = 2'b10; s_funct = F_MULTU; s_a = 8'hFF; s_b = 8'hFF; s_in_valid = 1'b1;
        @(posedge clk); #1; s_in_valid = 1'b0;
        n = 0;
        while (!s_md_done && n < 100) begin @(posedge clk); #1; n++; end
        chk("w8_latency", 64'(n), 64'(SW + 1));
        chk("w8_hi", s_hi, 8'hFE);
        chk("w8_lo", s_lo, 8'h01);
        s_funct = F_SLT; s_a = 8'h80; s_b = 8'h01; s_in_valid = 1'b1;
        #1 chk("w8_slt_ctr", s_alu_ctr, 4'b0111);
        @(posedge clk); #1;
        chk("w8_sltu_a", s_result, 8'h00);
        s_a = 8'h01; s_b = 8'h80;
        @(posedge clk); #1; s_in_valid = 1'b0;
        chk("w8_sltu_b", s_result, 8'h01);
        chk("w8_ov", s_out_valid, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes the 2-bit main-control ALU op and the R-type funct field, and executes the operation itself. Simple ops return a registered result one cycle after issue. MULT/MULTU/DIV/DIVU run on an iterative multiply/divide engine that writes the HI/LO registers, with a valid/ready issue handshake that stalls the datapath while busy. It sits in the EX stage between the register-file operands and the writeback mux.

Parameters:
WIDTH, 32, operand/result/HI/LO width in bits; must be >=4 and even.
SLT_SIGNED, 1, 1 = SLT compares signed, 0 = unsigned compare.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operation presented this cycle
in_ready  output  1  unit can accept an operation
alu_op  input  2  main-control op: 00 add, 01 sub, 1x R-type (use funct)
funct  input  6  R-type funct field
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt or immediate)
alu_ctr  output  4  combinational decode: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1111 other/illegal
result  output  WIDTH  registered result of simple op / MFHI / MFLO
out_valid  output  1  one-cycle pulse: result valid
zero  output  1  result == 0, qualified by out_valid
md_done  output  1  one-cycle pulse: HI/LO updated by mult/div
illegal  output  1  one-cycle pulse: unknown funct accepted
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state IDLE; result, hi, lo = 0; out_valid, md_done, illegal = 0; in_ready = 1. Reset during MUL/DIV aborts the operation; HI/LO are cleared and not written.
- Accept happens on a rising edge with in_valid & in_ready. in_ready = 1 only in IDLE. When in_ready = 0, in_valid is ignored and a, b, funct need not be held.
- Decode (alu_op=1x): 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo. Any other funct is illegal. alu_ctr is purely combinational, even when in_valid = 0.
- Simple ops (add/sub/and/or/slt/mfhi/mflo): on accept, result is registered. out_valid pulses in the following cycle (latency 1). State stays IDLE, so back-to-back issue is allowed every cycle. Add/sub wrap modulo 2^WIDTH, with no overflow flag. slt gives 1 or 0, zero-extended.
- Illegal: result = 0, out_valid = 1, and illegal = 1 for one cycle.
- FSM states: IDLE -> MUL | DIV on accept of a mult-class op -> FIX after WIDTH iteration edges -> IDLE.
  - MUL: shift-add, one bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - FIX: sign correction, then HI/LO write.
- Mult/div latency: accept at edge 0, iterations at edges 1..WIDTH, FIX at edge WIDTH+1. md_done = 1 and in_ready = 1 in the cycle after edge WIDTH+1. Latency is identical for signed and unsigned ops. out_valid is not pulsed for mult/div.
- Signed mult/div: operate on magnitudes and correct signs in FIX.
  - Product is a full 2*WIDTH bits: HI = upper half, LO = lower half.
  - Quotient (LO) truncates toward zero; remainder (HI) takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = a. Takes the normal latency; no flag.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- MFHI/MFLO issued the cycle md_done is high read the new HI/LO.

Test Plan:
1. Reset mid-MULT (cycle 10), WIDTH=32 -> hi = lo = 0, in_ready = 1 immediately, no md_done pulse.
2. alu_op=10, funct=100010, a=5, b=7 -> alu_ctr=0110; next cycle result=0xFFFFFFFE, out_valid=1, zero=0. Then issue slt on the same operands back-to-back -> result=1.
3. MULT a=0xFFFFFFFD (-3), b=7 -> in_ready low 33 cycles; md_done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MFLO -> result=0xFFFFFFEB.
4. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
5. funct=111111, alu_op=10 -> alu_ctr=1111, result=0, out_valid=1, illegal=1 for exactly one cycle. Asserting in_valid during DIV busy -> op not accepted, no output pulse.
6. WIDTH=8: MULTU a=0xFF, b=0xFF -> hi=0xFE, lo=0x01; md_done 9 cycles after accept.
